pilot_sym_sched: RTL and testbench
==================================

// Module: pilot_sym_sched
// PURPOSE
//  Symbol scheduler in front of the pilot-insertion stage. Sequences one frame of
//  NUM_SYM OFDM symbols into it: 48 contiguous data samples per symbol with index
//  0..47, then an inter-symbol gap so the 64-point ping-pong readout can drain.
//  Also generates the per-symbol pilot polarity (802.11a PN127 sequence).
//  Zero-pads to keep the downstream burst contiguous if upstream starves.
// PARAMETERS
//  DATAWIDTH   16  width of real/imag samples
//  GAP_CYCLES  16  idle cycles between symbol bursts (>=16 for 64-pt readout)
//  SYM_W       8   width of symbol counter / num_symbols
// PORTS
//  sched_clk      in   1          clock, all logic on rising edge
//  sched_rst      in   1          reset, asynchronous, active-high
//  frame_start    in   1          1-cycle pulse: start frame (ignored while busy)
//  num_symbols    in   SYM_W      symbols in frame; sampled on accepted frame_start
//  up_valid       in   1          upstream sample valid
//  up_real        in   DATAWIDTH  upstream real part
//  up_imag        in   DATAWIDTH  upstream imag part
//  up_ready       out  1          sample accepted when up_valid & up_ready
//  dout_index     out  6          subcarrier index 0..47 of dout sample
//  dout_valid     out  1          to pilot stage din_valid
//  dout_real      out  DATAWIDTH  to pilot stage real input
//  dout_imag      out  DATAWIDTH  to pilot stage imag input
//  pilot_pol      out  1          1 = negate pilots for current symbol
//  sym_cnt        out  SYM_W      index of symbol currently being sent
//  busy           out  1          high from accepted frame_start until frame_done
//  frame_done     out  1          1-cycle pulse after last symbol's gap
//  err_underrun   out  1          1-cycle pulse per zero-padded sample
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, PN LFSR=7'h7F, counters 0.
//  FSM: IDLE -> (frame_start & num_symbols!=0) -> LOAD; num_symbols==0 -> DONE.
//   LOAD: 48 sample slots, slot counter 0..47; slot 47 -> GAP.
//   GAP: GAP_CYCLES cycles; then sym_cnt==num_symbols-1 -> DONE else sym_cnt++, LOAD.
//   DONE: frame_done=1 for one cycle, busy=0, -> IDLE.
//  up_ready = (state==LOAD), combinational from state only (no up_valid dependence).
//  Each LOAD cycle emits exactly one slot: dout_* registered, 1-cycle latency;
//   dout_valid=1, dout_index=slot. up_valid=1 -> data passed; up_valid=0 -> data=0,
//   err_underrun=1, slot still consumed (burst never breaks).
//  dout_valid=0 and dout_real/imag=0 outside LOAD-issued slots.
//  Pilot polarity: LFSR x^7+x^4+1, out=s[6]^s[3], shift {s[5:0],out}. Seeded 7'h7F
//   on accepted frame_start; one step at each LOAD entry; pilot_pol=out, held
//   constant for whole symbol. First 8 symbols: 0,0,0,0,1,1,1,0.
//  num_symbols latched at frame_start; later changes have no effect on the frame.
//  frame_start while busy ignored; frame_start same cycle as frame_done ignored.
//  Symbol period = 48+GAP_CYCLES cycles; frame length = NUM_SYM*(48+GAP)+2 cycles.
//  Reset asserted mid-frame: immediate return to reset state, outputs 0.
// TESTING
//  1 symbol, up_valid=1 always, data=k -> dout_index 0..47, dout_real=k, 16-cycle gap,
//   frame_done one cycle later, pilot_pol=0.
//  num_symbols=8 -> pilot_pol per symbol 0,0,0,0,1,1,1,0; sym_cnt 0..7; bursts 64 cycles apart.
//  up_valid low at slots 10-12 -> dout zero there, 3 err_underrun pulses, index stays contiguous.
//  frame_start repeated while busy, num_symbols changed mid-frame -> no effect.
//  num_symbols=0 -> frame_done pulse, no dout_valid.
//  sched_rst asserted at slot 30 of symbol 2 -> outputs 0 async; new frame restarts PN at 7'h7F.

Source files
------------

// File: rtl/pilot_sym_sched.sv
// Frame scheduler for the pilot stage: 48 data slots plus a drain gap per symbol, with PN127 pilot polarity.
// dout_* 1-cycle latency; up_ready only in slot cycles, a starved slot is zero-padded so the burst never breaks.
module pilot_sym_sched #(
    parameter int DATAWIDTH  = 16,
    parameter int GAP_CYCLES = 16,
    parameter int SYM_W      = 8
) (
    input  logic                 sched_clk,
    input  logic                 sched_rst,
    input  logic                 frame_start,
    input  logic [SYM_W-1:0]     num_symbols,
    input  logic                 up_valid,
    input  logic [DATAWIDTH-1:0] up_real,
    input  logic [DATAWIDTH-1:0] up_imag,
    output logic                 up_ready,
    output logic [5:0]           dout_index,
    output logic                 dout_valid,
    output logic [DATAWIDTH-1:0] dout_real,
    output logic [DATAWIDTH-1:0] dout_imag,
    output logic                 pilot_pol,
    output logic [SYM_W-1:0]     sym_cnt,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_underrun
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [5:0]           slot_q, slot_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [SYM_W-1:0]     sym_q, sym_d;
    logic [SYM_W-1:0]     nsym_q, nsym_d;
    logic [6:0]           lfsr_q, lfsr_d;
    logic                 pol_q, pol_d;
    logic                 dvld_q, dvld_d;
    logic [5:0]           didx_q, didx_d;
    logic [DATAWIDTH-1:0] dre_q, dre_d;
    logic [DATAWIDTH-1:0] dim_q, dim_d;
    logic                 und_q, und_d;
    logic [6:0]           lfsr_src;
    logic                 lfsr_fb;

    // A new frame steps from the seed rather than from whatever the previous frame left behind.
    assign lfsr_src = (state_q == S_IDLE) ? 7'h7F : lfsr_q;
    assign lfsr_fb  = lfsr_src[6] ^ lfsr_src[3];

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        gap_d   = gap_q;
        sym_d   = sym_q;
        nsym_d  = nsym_q;
        lfsr_d  = lfsr_q;
        pol_d   = pol_q;
        dvld_d  = 1'b0;
        didx_d  = 6'd0;
        dre_d   = '0;
        dim_d   = '0;
        und_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    sym_d  = '0;
                    nsym_d = num_symbols;
                    lfsr_d = 7'h7F;
                    if (num_symbols != '0) begin
                        state_d = S_LOAD;
                        slot_d  = 6'd0;
                        lfsr_d  = {lfsr_src[5:0], lfsr_fb};
                        pol_d   = lfsr_fb;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                dvld_d = 1'b1;
                didx_d = slot_q;
                if (up_valid) begin
                    dre_d = up_real;
                    dim_d = up_imag;
                end else begin
                    und_d = 1'b1;
                end
                if (slot_q == 6'd47) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    slot_d = slot_q + 6'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (sym_q == nsym_q - SYM_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        sym_d   = sym_q + SYM_W'(1);
                        slot_d  = 6'd0;
                        lfsr_d  = {lfsr_src[5:0], lfsr_fb};
                        pol_d   = lfsr_fb;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sched_clk or posedge sched_rst) begin
        if (sched_rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            gap_q   <= '0;
            sym_q   <= '0;
            nsym_q  <= '0;
            lfsr_q  <= 7'h7F;
            pol_q   <= 1'b0;
            dvld_q  <= 1'b0;
            didx_q  <= '0;
            dre_q   <= '0;
            dim_q   <= '0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            gap_q   <= gap_d;
            sym_q   <= sym_d;
            nsym_q  <= nsym_d;
            lfsr_q  <= lfsr_d;
            pol_q   <= pol_d;
            dvld_q  <= dvld_d;
            didx_q  <= didx_d;
            dre_q   <= dre_d;
            dim_q   <= dim_d;
            und_q   <= und_d;
        end
    end

    assign up_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD) || (state_q == S_GAP);
    assign frame_done   = (state_q == S_DONE);
    assign dout_valid   = dvld_q;
    assign dout_index   = didx_q;
    assign dout_real    = dre_q;
    assign dout_imag    = dim_q;
    assign err_underrun = und_q;
    assign pilot_pol    = pol_q;
    assign sym_cnt      = sym_q;
endmodule

// File: tb/tb_pilot_sym_sched.sv
// Scenario table plus a cycle-position reference model for pilot_sym_sched.
module tb_pilot_sym_sched;
    localparam int DW  = 16;
    localparam int GAP = 16;
    localparam int SW  = 8;
    localparam int PER = 48 + GAP;

    logic          sched_clk = 1'b0;
    logic          sched_rst;
    logic          frame_start;
    logic [SW-1:0] num_symbols;
    logic          up_valid;
    logic [DW-1:0] up_real, up_imag;
    logic          up_ready, dout_valid, pilot_pol, busy, frame_done, err_underrun;
    logic [5:0]    dout_index;
    logic [DW-1:0] dout_real, dout_imag;
    logic [SW-1:0] sym_cnt;

    pilot_sym_sched #(.DATAWIDTH(DW), .GAP_CYCLES(GAP), .SYM_W(SW)) dut (
        .sched_clk(sched_clk), .sched_rst(sched_rst), .frame_start(frame_start),
        .num_symbols(num_symbols), .up_valid(up_valid), .up_real(up_real), .up_imag(up_imag),
        .up_ready(up_ready), .dout_index(dout_index), .dout_valid(dout_valid),
        .dout_real(dout_real), .dout_imag(dout_imag), .pilot_pol(pilot_pol),
        .sym_cnt(sym_cnt), .busy(busy), .frame_done(frame_done), .err_underrun(err_underrun)
    );

    always #5 sched_clk = ~sched_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pilot polarity of symbol n, from the bit recurrence x[n+7] = x[n] ^ x[n+3] with seed all ones.
    bit pn_tab [0:255];

    // Reference model: everything follows from the position of a cycle relative to the accepted frame_start.
    bit            act;
    int            t0, nsym;
    bit            pv;
    logic [DW-1:0] pr, pim;
    int            vld_cnt, und_cnt, done_cyc, und_drv;
    logic [7:0]    pol_seen;

    always @(negedge sched_clk) begin : model
        int r, q, e_sym, e_idx;
        bit e_busy, e_rdy, e_done, e_vld, e_und, start_ok;
        logic [DW-1:0] e_re, e_im;
        if (sched_rst) begin
            act = 0;
            chk("rst_ctrl", 32'({dout_valid, busy, frame_done, err_underrun, up_ready, pilot_pol}), 0);
            chk("rst_data", 32'({dout_real, dout_imag}), 0);
            chk("rst_sym", 32'(sym_cnt), 0);
        end else begin
            e_busy = 0; e_rdy = 0; e_done = 0; e_vld = 0; e_und = 0;
            e_sym = 0; e_idx = 0; e_re = '0; e_im = '0; r = -1;
            if (act) begin
                r = cyc - t0 - 1;
                if (r >= 0 && r < nsym * PER) begin
                    e_busy = 1;
                    e_rdy  = (r % PER) < 48;
                    e_sym  = r / PER;
                end
                e_done = (r == nsym * PER);
                q = r - 1;
                if (q >= 0 && q / PER < nsym && q % PER < 48) begin
                    e_vld = 1;
                    e_idx = q % PER;
                    e_re  = pv ? pr : '0;
                    e_im  = pv ? pim : '0;
                    e_und = !pv;
                end
            end
            chk("up_ready", 32'(up_ready), 32'(e_rdy));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("frame_done", 32'(frame_done), 32'(e_done));
            chk("dout_valid", 32'(dout_valid), 32'(e_vld));
            chk("err_underrun", 32'(err_underrun), 32'(e_und));
            chk("dout_data", 32'({dout_real, dout_imag}), 32'({e_re, e_im}));
            if (e_vld) chk("dout_index", 32'(dout_index), e_idx);
            if (e_busy) begin
                chk("sym_cnt", 32'(sym_cnt), e_sym);
                chk("pilot_pol", 32'(pilot_pol), 32'(pn_tab[e_sym]));
                if (r % PER == 0 && e_sym < 8) pol_seen[e_sym] = pilot_pol;
            end
            if (dout_valid) vld_cnt++;
            if (err_underrun) und_cnt++;
            if (frame_done) done_cyc = cyc;
            start_ok = !act;
            if (act && r >= nsym * PER) act = 0;
            if (start_ok && frame_start) begin
                act  = 1;
                t0   = cyc;
                nsym = int'(num_symbols);
            end
        end
        pv  = sched_rst ? 1'b0 : up_valid;
        pr  = up_real;
        pim = up_imag;
        cyc++;
    end

    // mode 0: always valid, data = slot; mode 1: starve slots 10..12; mode 2: random valid and data.
    task automatic set_inputs(input int k, input int n, input int mode, input bit spur);
        int slot;
        slot = (k > 0) ? (k - 1) % PER : 0;
        frame_start = (k == 0) || (spur && (k == 20 || k == 100 || k == n * PER + 1));
        num_symbols = (k == 0 || !spur) ? SW'(n) : SW'($urandom_range(1, 9));
        case (mode)
            0: up_valid = 1'b1;
            1: up_valid = !(slot >= 10 && slot <= 12);
            default: up_valid = ($urandom % 4) != 0;
        endcase
        if (mode == 0) begin
            up_real = DW'(slot);
            up_imag = DW'(16'hA000 | slot);
        end else begin
            up_real = DW'($urandom);
            up_imag = DW'($urandom);
        end
        if (k >= 1 && (k - 1) < n * PER && slot < 48 && !up_valid) und_drv++;
    endtask

    task automatic idle_inputs();
        frame_start = 0; up_valid = 0; up_real = '0; up_imag = '0;
    endtask

    task automatic run_frame(input int n, input int mode, input bit spur, input int exp_vld,
                             input int exp_und, input int exp_len, input logic [7:0] exp_pol);
        logic [7:0] mask;
        vld_cnt = 0; und_cnt = 0; done_cyc = -1; pol_seen = '0; und_drv = 0; t0 = 0;
        for (int k = 0; k < n * PER + 8; k++) begin
            set_inputs(k, n, mode, spur);
            @(posedge sched_clk); #1;
            if (done_cyc >= 0) break;
        end
        idle_inputs();
        repeat (3) @(posedge sched_clk);
        #1;
        chk("busy_after_frame", 32'(busy), 0);
        chk("vld_count", vld_cnt, exp_vld);
        chk("underrun_count", und_cnt, (exp_und < 0) ? und_drv : exp_und);
        chk("frame_len", (done_cyc < 0) ? -1 : done_cyc - t0 + 1, exp_len);
        mask = (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
        if (n > 0) chk("pol_sequence", 32'(pol_seen & mask), 32'(exp_pol));
    endtask

    typedef struct {
        int n; int mode; bit spur; int exp_vld; int exp_und; int exp_len; logic [7:0] exp_pol;
    } vec_t;
    vec_t tbl [6];

    initial begin
        bit x [0:270];
        int rn;
        for (int i = 0; i < 7; i++) x[i] = 1;
        for (int i = 0; i < 256; i++) begin
            x[i + 7] = x[i] ^ x[i + 3];
            pn_tab[i] = x[i + 7];
        end

        tbl[0] = '{1, 0, 0, 48, 0, 66, 8'h00};
        tbl[1] = '{8, 0, 0, 384, 0, 514, 8'h70};
        tbl[2] = '{2, 1, 0, 96, 6, 130, 8'h00};
        tbl[3] = '{3, 0, 1, 144, 0, 194, 8'h00};
        tbl[4] = '{0, 0, 0, 0, 0, 2, 8'h00};
        tbl[5] = '{2, 2, 0, 96, -1, 130, 8'h00};

        sched_rst = 1; num_symbols = '0;
        idle_inputs();
        repeat (2) @(posedge sched_clk);
        #1;
        chk("reset_outputs", 32'({dout_valid, busy, frame_done, err_underrun, up_ready, pilot_pol}), 0);
        chk("reset_sym_cnt", 32'(sym_cnt), 0);
        sched_rst = 0;
        @(posedge sched_clk); #1;

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].n, tbl[i].mode, tbl[i].spur, tbl[i].exp_vld, tbl[i].exp_und,
                      tbl[i].exp_len, tbl[i].exp_pol);

        for (int i = 0; i < 3; i++) begin
            rn = $urandom_range(1, 4);
            run_frame(rn, 2, bit'($urandom % 2), rn * 48, -1, rn * PER + 2, 8'h00);
        end

        // Reset during slot 30 of symbol 2, then a fresh frame must restart the PN sequence.
        und_drv = 0; done_cyc = -1;
        for (int k = 0; k < 2 * PER + 31; k++) begin
            set_inputs(k, 4, 0, 0);
            @(posedge sched_clk); #1;
        end
        set_inputs(2 * PER + 31, 4, 0, 0);
        chk("pre_reset_valid", 32'(dout_valid), 1);
        chk("pre_reset_sym", 32'(sym_cnt), 2);
        #1 sched_rst = 1;
        #1;
        chk("async_rst_ctrl", 32'({dout_valid, busy, up_ready, err_underrun, pilot_pol}), 0);
        chk("async_rst_data", 32'({dout_real, dout_imag}), 0);
        chk("async_rst_sym", 32'(sym_cnt), 0);
        idle_inputs();
        repeat (2) @(posedge sched_clk);
        #1 sched_rst = 0;
        @(posedge sched_clk); #1;
        run_frame(5, 0, 0, 240, 0, 5 * PER + 2, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
